// File: rtl/mio_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mio_bus_arbiter_if
//   One MIO request/response channel: a core-side port of the arbiter or
//   the arbiter-to-memory/IO port.
//
//   req    : request, held by the requester until ready is seen
//   we     : write enable (1 = write, 0 = read)
//   addr   : byte address
//   wdata  : write data
//   rdata  : read data, returned by the responder
//   ready  : completion pulse, returned by the responder
//
//   Modports:
//     master : issues requests (drives req/we/addr/wdata)
//     slave  : answers requests (drives rdata/ready)
// ---------------------------------------------------------------------------
interface mio_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ready
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready
    );
endinterface

// File: rtl/mio_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mio_bus_arbiter
//   Two-master round-robin arbiter that serialises MIO transactions from two
//   multi-cycle CPU cores onto one memory/IO bus. The owning core gets its
//   read data and a single-cycle ready pulse when the bus phase completes.
//
//   Ports:
//     clk          : system clock, rising edge
//     reset        : asynchronous, active-low reset
//     m0, m1       : core-side channels (slave modport; cores are masters)
//     s            : memory/IO-side channel (master modport)
//     grant        : one-hot current owner {m1,m0}, 00 when idle
//     arb_state    : FSM state (IDLE=00, BUS0=01, BUS1=10, DONE=11)
//     timeout_err  : sticky bus timeout flag
//
//   Optional feature (compile-time macro ARB_TIMEOUT_EN):
//     defined   : a granted transaction that sees no s.ready for TIMEOUT
//                 bus cycles is completed with read data 32'hDEADBEEF and
//                 timeout_err is raised until reset.
//     undefined : the bus phase waits for s.ready indefinitely and
//                 timeout_err stays 0.
//
//   Every output comes straight from a flop; no input reaches an output
//   combinationally.
// ---------------------------------------------------------------------------
module mio_bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    mio_bus_arbiter_if.slave        m0,
    mio_bus_arbiter_if.slave        m1,
    mio_bus_arbiter_if.master       s,
    output logic [1:0]              grant,
    output logic [1:0]              arb_state,
    output logic                    timeout_err
);

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS0 = 2'b01,
        ST_BUS1 = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        s_req_q, s_req_d;
    logic        s_we_q, s_we_d;
    logic [31:0] s_addr_q, s_addr_d;
    logic [31:0] s_wdata_q, s_wdata_d;
    logic [31:0] m0_rdata_q, m0_rdata_d;
    logic [31:0] m1_rdata_q, m1_rdata_d;
    logic        m0_ready_q, m0_ready_d;
    logic        m1_ready_q, m1_ready_d;
    logic [1:0]  grant_q, grant_d;
    logic        timeout_err_q, timeout_err_d;

    logic        any_req;
    logic        pick_m1;
    logic        tmo_hit;
    logic        bus_done;
    logic [31:0] done_rdata;

`ifdef ARB_TIMEOUT_EN
    logic [7:0]  cnt_q, cnt_d;

    // The counter holds the number of bus cycles already spent; the cycle
    // that would bring it to TIMEOUT is the last one allowed. A late
    // s.ready in that same cycle still wins over the timeout.
    always_comb begin
        tmo_hit = ~s.ready & ((cnt_q + 8'd1) == 8'(TIMEOUT));
    end
`else
    logic [7:0]  unused_timeout;

    assign unused_timeout = 8'(TIMEOUT);
    assign tmo_hit        = 1'b0;
`endif

    // Round-robin choice: m1 wins when it is alone, or when both request
    // and m0 was the most recent owner (last_q == 0).
    always_comb begin
        any_req    = m0.req | m1.req;
        pick_m1    = m1.req & (~m0.req | ~last_q);
        bus_done   = s.ready | tmo_hit;
        done_rdata = s.ready ? s.rdata : TIMEOUT_RDATA;
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            last_q        <= 1'b1;
            s_req_q       <= 1'b0;
            s_we_q        <= 1'b0;
            s_addr_q      <= '0;
            s_wdata_q     <= '0;
            m0_rdata_q    <= '0;
            m1_rdata_q    <= '0;
            m0_ready_q    <= 1'b0;
            m1_ready_q    <= 1'b0;
            grant_q       <= 2'b00;
            timeout_err_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            s_req_q       <= s_req_d;
            s_we_q        <= s_we_d;
            s_addr_q      <= s_addr_d;
            s_wdata_q     <= s_wdata_d;
            m0_rdata_q    <= m0_rdata_d;
            m1_rdata_q    <= m1_rdata_d;
            m0_ready_q    <= m0_ready_d;
            m1_ready_q    <= m1_ready_d;
            grant_q       <= grant_d;
            timeout_err_q <= timeout_err_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = pick_m1 ? ST_BUS1 : ST_BUS0;
                end
            end
            ST_BUS0, ST_BUS1: begin
                if (bus_done) begin
                    state_d = ST_DONE;
                end
            end
            // DONE always returns to IDLE; requests seen here are ignored so
            // that a master still holding req is re-arbitrated fairly.
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output / datapath next values
    // -----------------------------------------------------------------------
    always_comb begin
        last_d        = last_q;
        s_req_d       = s_req_q;
        s_we_d        = s_we_q;
        s_addr_d      = s_addr_q;
        s_wdata_d     = s_wdata_q;
        m0_rdata_d    = m0_rdata_q;
        m1_rdata_d    = m1_rdata_q;
        m0_ready_d    = 1'b0;
        m1_ready_d    = 1'b0;
        grant_d       = grant_q;
        timeout_err_d = timeout_err_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    s_req_d   = 1'b1;
                    s_we_d    = pick_m1 ? m1.we    : m0.we;
                    s_addr_d  = pick_m1 ? m1.addr  : m0.addr;
                    s_wdata_d = pick_m1 ? m1.wdata : m0.wdata;
                    grant_d   = pick_m1 ? 2'b10    : 2'b01;
`ifdef ARB_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end

            ST_BUS0, ST_BUS1: begin
                if (bus_done) begin
                    s_req_d       = 1'b0;
                    timeout_err_d = timeout_err_q | tmo_hit;
                    if (state_q == ST_BUS1) begin
                        last_d     = 1'b1;
                        m1_ready_d = 1'b1;
                        if (!s_we_q) begin
                            m1_rdata_d = done_rdata;
                        end
                    end else begin
                        last_d     = 1'b0;
                        m0_ready_d = 1'b1;
                        if (!s_we_q) begin
                            m0_rdata_d = done_rdata;
                        end
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end

            default: begin
                grant_d = 2'b00;
            end
        endcase
    end

    assign s.req       = s_req_q;
    assign s.we        = s_we_q;
    assign s.addr      = s_addr_q;
    assign s.wdata     = s_wdata_q;
    assign m0.rdata    = m0_rdata_q;
    assign m0.ready    = m0_ready_q;
    assign m1.rdata    = m1_rdata_q;
    assign m1.ready    = m1_ready_q;
    assign grant       = grant_q;
    assign arb_state   = state_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mio_bus_arbiter
//   Directed and randomized bench for mio_bus_arbiter. A behavioural model
//   (priority pointer, per-master read data, sticky error) predicts every
//   grant, bus phase and completion. Inputs change and outputs are sampled
//   on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mio_bus_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] grant;
    logic [1:0] arb_state;
    logic       timeout_err;

    always #5 clk = ~clk;

    mio_bus_arbiter_if m0_if ();
    mio_bus_arbiter_if m1_if ();
    mio_bus_arbiter_if s_if ();

    mio_bus_arbiter #(.TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .m0          (m0_if),
        .m1          (m1_if),
        .s           (s_if),
        .grant       (grant),
        .arb_state   (arb_state),
        .timeout_err (timeout_err)
    );

    // Bench-driven stimulus
    logic        b_req   [2];
    logic        b_we    [2];
    logic [31:0] b_addr  [2];
    logic [31:0] b_wdata [2];
    logic        s_ready_b;
    logic [31:0] s_rdata_b;

    assign m0_if.req   = b_req[0];
    assign m0_if.we    = b_we[0];
    assign m0_if.addr  = b_addr[0];
    assign m0_if.wdata = b_wdata[0];
    assign m1_if.req   = b_req[1];
    assign m1_if.we    = b_we[1];
    assign m1_if.addr  = b_addr[1];
    assign m1_if.wdata = b_wdata[1];
    assign s_if.ready  = s_ready_b;
    assign s_if.rdata  = s_rdata_b;

    // Reference model state
    int          last_m;
    logic [31:0] exp_rd [2];
    logic        exp_err;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Round-robin rule: a lone requester wins; on a tie the master that
    // was not served last wins.
    function automatic int winner();
        if (b_req[0] && b_req[1]) return (last_m == 1) ? 0 : 1;
        else if (b_req[1])        return 1;
        else                      return 0;
    endfunction

    task automatic new_req(input int m);
        b_req[m]   = 1'b1;
        b_we[m]    = 1'($urandom_range(0, 1));
        b_addr[m]  = $urandom;
        b_wdata[m] = $urandom;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_grant"},  grant,         0);
        chk({tag, "_state"},  arb_state,     0);
        chk({tag, "_s_req"},  s_if.req,      0);
        chk({tag, "_s_we"},   s_if.we,       0);
        chk({tag, "_s_addr"}, s_if.addr,     0);
        chk({tag, "_s_wd"},   s_if.wdata,    0);
        chk({tag, "_m0_rd"},  m0_if.rdata,   0);
        chk({tag, "_m1_rd"},  m1_if.rdata,   0);
        chk({tag, "_m0_rdy"}, m0_if.ready,   0);
        chk({tag, "_m1_rdy"}, m1_if.ready,   0);
        chk({tag, "_err"},    timeout_err,   0);
    endtask

    // Called at a falling edge; reset is asserted immediately and the
    // outputs must clear without waiting for a clock edge.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        chk_outputs_zero(tag);
        step();
        step();
        reset     = 1'b1;
        last_m    = 1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        exp_err   = 1'b0;
    endtask

    // One complete transaction starting from IDLE with at least one request
    // pending. next_mode: 0 = random follow-up, 1 = winner keeps its
    // request, 2 = winner drops its request.
    task automatic serve(input int waits, input bit tmo, input int next_mode,
                         input logic [31:0] rd, output logic [1:0] g_obs);
        int          w;
        int          o;
        int          n;
        logic        we_s;
        logic [31:0] a_s;
        logic [31:0] d_s;
        w    = winner();
        o    = 1 - w;
        we_s = b_we[w];
        a_s  = b_addr[w];
        d_s  = b_wdata[w];

        step();  // request sampled in IDLE
        g_obs = grant;
        chk("e1_grant",  grant,       (w == 1) ? 32'd2 : 32'd1);
        chk("e1_state",  arb_state,   (w == 1) ? 32'd2 : 32'd1);
        chk("e1_s_req",  s_if.req,    1);
        chk("e1_s_we",   s_if.we,     we_s);
        chk("e1_s_addr", s_if.addr,   a_s);
        chk("e1_s_wd",   s_if.wdata,  d_s);
        chk("e1_m0_rdy", m0_if.ready, 0);
        chk("e1_m1_rdy", m1_if.ready, 0);

        n = tmo ? (TMO - 1) : waits;
        for (int i = 0; i < n; i++) begin
            s_ready_b = 1'b0;
            s_rdata_b = $urandom;
            step();
            chk("wt_s_req",  s_if.req,    1);
            chk("wt_s_we",   s_if.we,     we_s);
            chk("wt_s_addr", s_if.addr,   a_s);
            chk("wt_s_wd",   s_if.wdata,  d_s);
            chk("wt_state",  arb_state,   (w == 1) ? 32'd2 : 32'd1);
            chk("wt_m0_rdy", m0_if.ready, 0);
            chk("wt_m1_rdy", m1_if.ready, 0);
        end

        s_ready_b = !tmo;
        s_rdata_b = rd;
        step();  // completion edge
        last_m = w;
        if (!we_s) exp_rd[w] = tmo ? 32'hDEADBEEF : rd;
        if (tmo) exp_err = 1'b1;
        chk("dn_state",   arb_state,   3);
        chk("dn_rdy_win", (w == 1) ? m1_if.ready : m0_if.ready, 1);
        chk("dn_rdy_oth", (o == 1) ? m1_if.ready : m0_if.ready, 0);
        chk("dn_s_req",   s_if.req,    0);
        chk("dn_grant",   grant,       (w == 1) ? 32'd2 : 32'd1);
        chk("dn_m0_rd",   m0_if.rdata, exp_rd[0]);
        chk("dn_m1_rd",   m1_if.rdata, exp_rd[1]);
        chk("dn_err",     timeout_err, exp_err);

        case (next_mode)
            0: begin
                if ($urandom_range(0, 1) == 1) new_req(w);
                else b_req[w] = 1'b0;
                if (!b_req[o] && $urandom_range(0, 2) == 0) new_req(o);
            end
            1: ;
            default: b_req[w] = 1'b0;
        endcase
        // Slave activity during DONE must be ignored.
        s_ready_b = 1'($urandom_range(0, 1));
        s_rdata_b = $urandom;

        step();  // back to IDLE
        chk("e3_state",  arb_state,   0);
        chk("e3_grant",  grant,       0);
        chk("e3_m0_rdy", m0_if.ready, 0);
        chk("e3_m1_rdy", m1_if.ready, 0);
        chk("e3_s_req",  s_if.req,    0);
        chk("e3_m0_rd",  m0_if.rdata, exp_rd[0]);
        chk("e3_m1_rd",  m1_if.rdata, exp_rd[1]);
        chk("e3_err",    timeout_err, exp_err);
        s_ready_b = 1'b0;
    endtask

    initial begin
        logic [1:0] g;
        logic [1:0] gseq [4];
        logic [1:0] gexp [4];
        logic [31:0] rd;

        gexp[0] = 2'b01; gexp[1] = 2'b10; gexp[2] = 2'b01; gexp[3] = 2'b10;
        reset = 1'b1;
        for (int m = 0; m < 2; m++) begin
            b_req[m] = 1'b0; b_we[m] = 1'b0; b_addr[m] = '0; b_wdata[m] = '0;
        end
        s_ready_b = 1'b0;
        s_rdata_b = '0;

        // Reset state and idle behaviour
        @(negedge clk);
        do_reset("rst0");
        s_ready_b = 1'b1;  // ignored in IDLE
        step();
        step();
        chk("idle_state", arb_state, 0);
        chk("idle_s_req", s_if.req,  0);
        chk("idle_m0rdy", m0_if.ready, 0);
        s_ready_b = 1'b0;

        // m0 reads 0x100, zero-wait slave returns 0x12345678
        b_req[0] = 1'b1; b_we[0] = 1'b0; b_addr[0] = 32'h100; b_wdata[0] = $urandom;
        serve(0, 1'b0, 2, 32'h12345678, g);
        chk("t1_m0_rdata", m0_if.rdata, 32'h12345678);

        // Both request from reset: strict alternation 0,1,0,1
        do_reset("rst1");
        new_req(0);
        new_req(1);
        for (int k = 0; k < 4; k++) begin
            serve(int'($urandom_range(0, 2)), 1'b0, 1, $urandom, g);
            gseq[k] = g;
        end
        for (int k = 0; k < 4; k++) chk("fair_seq", gseq[k], gexp[k]);
        b_req[0] = 1'b0;
        b_req[1] = 1'b0;
        step();

        // m1 writes 0xCAFEF00D to 0x200 with 3 wait cycles
        b_req[1] = 1'b1; b_we[1] = 1'b1; b_addr[1] = 32'h200; b_wdata[1] = 32'hCAFEF00D;
        serve(0, 1'b0, 0, 32'h0, g);  // prime m1_rdata with a read first? no: m1 write only
        b_req[0] = 1'b0;
        b_req[1] = 1'b0;
        step();
        b_req[1] = 1'b1; b_we[1] = 1'b0; b_addr[1] = 32'h204;
        rd = $urandom;
        serve(1, 1'b0, 2, rd, g);
        b_req[0] = 1'b0;
        b_req[1] = 1'b1; b_we[1] = 1'b1; b_addr[1] = 32'h200; b_wdata[1] = 32'hCAFEF00D;
        serve(3, 1'b0, 2, $urandom, g);
        chk("wr_m1_rdata_kept", m1_if.rdata, rd);

        // Reset while in BUS1, then re-arbitration with m0 priority
        b_req[0] = 1'b0;
        b_req[1] = 1'b1; b_we[1] = 1'b1; b_addr[1] = 32'h300; b_wdata[1] = 32'h55AA55AA;
        step();
        chk("pre_rst_state", arb_state, 2);
        chk("pre_rst_grant", grant, 2);
        do_reset("rst_bus1");
        new_req(0);
        serve(0, 1'b0, 2, $urandom, g);
        chk("rearb_first", g, 2'b01);
        serve(0, 1'b0, 2, $urandom, g);
        chk("rearb_second", g, 2'b10);

        // m0 holds its request through DONE, m1 idle
        b_req[1] = 1'b0;
        new_req(0);
        serve(1, 1'b0, 1, $urandom, g);
        serve(0, 1'b0, 2, $urandom, g);
        chk("hold_second_grant", g, 2'b01);

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            if (!b_req[0] && !b_req[1]) new_req(int'($urandom_range(0, 1)));
            serve(int'($urandom_range(0, 3)), 1'b0, 0, $urandom, g);
        end
        b_req[0] = 1'b0;
        b_req[1] = 1'b0;
        step();

`ifdef ARB_TIMEOUT_EN
        // Slave never answers an m0 read
        b_req[0] = 1'b1; b_we[0] = 1'b0; b_addr[0] = 32'h400;
        serve(0, 1'b1, 2, $urandom, g);
        chk("tmo_rdata", m0_if.rdata, 32'hDEADBEEF);
        chk("tmo_err",   timeout_err, 1);
        new_req(1);
        serve(0, 1'b0, 2, $urandom, g);
        chk("tmo_err_sticky", timeout_err, 1);
`else
        chk("no_tmo_err", timeout_err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mio_bus_arbiter.md
# mio_bus_arbiter

Two-master round-robin arbiter sharing one memory/IO bus between two multi-cycle CPU cores. Each core's MIO request (CPU_MIO, mem_w, Addr_out, Data_out) enters a master port, and each core's MIO_ready/Data_in is driven from it. The arbiter serialises transactions onto a single slave port toward RAM/peripherals and returns read data and a one-cycle ready pulse to the owning core.

## Interface
- TIMEOUT, 255: max cycles a granted transaction waits for s_ready (8-bit counter; used only with ARB_TIMEOUT_EN).

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- m0_req  in  1  master 0 request (CPU_MIO); held until m0_ready
- m0_we  in  1  master 0 write enable (mem_w)
- m0_addr  in  32  master 0 address
- m0_wdata  in  32  master 0 write data
- m0_rdata  out  32  master 0 read data (to Data_in)
- m0_ready  out  1  master 0 completion pulse (to MIO_ready)
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ready: same as master 0, for master 1
- s_req  out  1  slave request, high for the whole bus phase
- s_we  out  1  slave write enable
- s_addr  out  32  slave address
- s_wdata  out  32  slave write data
- s_rdata  in  32  slave read data, valid when s_ready=1
- s_ready  in  1  slave completion, sampled only while s_req=1
- grant  out  2  one-hot current owner ({m1,m0}); 00 when idle
- arb_state  out  2  FSM state, for debug
- timeout_err  out  1  sticky timeout flag

## Operation
- States: IDLE=00, BUS0=01, BUS1=10, DONE=11.
- Priority pointer `last` (1 bit) is reset to 1, so master 0 wins the first tie.
- IDLE: one request -> grant it. Both requesting -> grant the master != last. No request -> stay.
- On grant: register the winner's addr/we/wdata into s_addr/s_we/s_wdata, set s_req=1, set grant, enter BUSn.
- BUSn: s_* remain stable. When s_ready=1: if !s_we, latch s_rdata into mn_rdata; set last=n; drop s_req; enter DONE with mn_ready=1.
- DONE: mn_ready high for exactly this cycle. All requests are ignored. Go to IDLE. grant clears on exit.
- mn_rdata holds its value until that master's next completed read. Writes do not alter it.
- s_ready is ignored in IDLE and DONE.
- Reset (any time, including mid-transaction): state=IDLE, last=1, all outputs 0 (rdata, ready, s_*, grant, arb_state, timeout_err). The in-flight transaction is dropped with no ready pulse.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Request sampled at edge E1 -> s_req high after E1.
- s_ready high before E2 -> mn_ready and mn_rdata valid after E2 for one cycle -> IDLE after E3.
- Minimum request-to-ready latency: 2 edges. Minimum back-to-back issue spacing: 3 cycles.
- A master still holding req during DONE is not re-granted until it is sampled in IDLE (E3 or later). The other master wins if both are pending.
- Fairness: with both masters continuously requesting, grants strictly alternate 0,1,0,1.

## Configuration
- ARB_TIMEOUT_EN defined: an 8-bit counter clears on entry to BUSn and increments each BUSn cycle.
  - When it reaches TIMEOUT without s_ready, the FSM goes to DONE and pulses mn_ready.
  - On a read, mn_rdata = 32'hDEADBEEF.
  - last updates as normal, and timeout_err is set and stays set until reset.
- ARB_TIMEOUT_EN undefined: BUSn waits for s_ready indefinitely, timeout_err is tied to 0, and TIMEOUT is unused.

## Test plan
- Reset released, m0 reads 0x100, slave returns 0x12345678 with zero wait -> s_req after E1, m0_ready pulse after E2, m0_rdata=0x12345678, grant=01 then 00.
- m0 and m1 request simultaneously from reset -> m0 served first, then m1. Held requests alternate 0,1,0,1 over 4 transactions.
- m1 writes 0xCAFEF00D to 0x200 with 3 slave wait cycles -> s_we=1 and s_addr/s_wdata stable for 4 cycles, m1_ready one cycle, m1_rdata unchanged.
- reset asserted while in BUS1 -> all outputs 0 immediately. After release, a pending m1_req is re-arbitrated from IDLE with m0 priority.
- m0 holds req through DONE while m1 is idle -> exactly one ready pulse per transaction, with the second grant no earlier than IDLE.
- ARB_TIMEOUT_EN, TIMEOUT=4, slave never ready, m0 read -> m0_ready after 4 BUS0 cycles, m0_rdata=0xDEADBEEF, timeout_err=1 and sticky.
